vend_sequencer: RTL and testbench
=================================

Name: vend_sequencer

Overview:
- Sequencing controller for the gruel vending datapath. It sits between the debounced, encoded coin inputs and the dispenser/change outputs.
- Accumulates credit from coin pulses and issues one gruel vend request when credit reaches PRICE.
- Returns change, or the full credit on cancel, one unit at a time through a req/ack handshake.
- Exposes state, credit and change totals for the seven-segment and LED drivers.

Parameters:
- PRICE, 4, cost of one gruel in coin units; legal range 1..12.
- HOLD_CYCLES, 8, cycles the gruel output stays asserted after a vend ack; must be at least 1.
- TIMEOUT_CYCLES, 1024, idle cycles in COLLECT before auto-refund; used only with VEND_TIMEOUT_EN.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- coin_valid  input  1  single-cycle coin-insert strobe.
- coin_value  input  2  encoded coin worth 1..3 units; 0 = no coin, ignored even when coin_valid=1.
- cancel  input  1  single-cycle refund request.
- vend_ack  input  1  dispenser accepted the vend.
- change_ack  input  1  coin hopper released one unit.
- vend_req  output  1  vend request, held until vend_ack.
- change_req  output  1  change-unit request, held until change_ack.
- gruel  output  1  dispensed indicator.
- coin_reject  output  1  one-cycle pulse when a coin is refused.
- state  output  3  encoded FSM state for display.
- credit  output  4  current accumulated credit.
- change_total  output  3  change/refund amount of the last transaction.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, internal change_left=0, hold counter=0.
- Reset mid-operation: returns to IDLE in the same edge, drops any pending request, discards credit.
- States and state encoding:
  - IDLE=0, COLLECT=1, VEND=2, HOLD=3, CHANGE=4.
  - All other encodings return to IDLE.
- Coin acceptance:
  - A coin is accepted only in IDLE or COLLECT when coin_valid=1 and coin_value!=0.
  - An accepted coin sets credit <= credit + coin_value, computed 4-bit with no overflow; maximum is PRICE+2.
- Coin rejection:
  - A coin arriving in VEND, HOLD or CHANGE is not counted.
  - coin_reject pulses high for exactly the next cycle.
- IDLE:
  - Accepted coin -> COLLECT.
  - change_total clears to 0 on the first accepted coin of a new transaction.
- COLLECT:
  - When new credit >= PRICE: go to VEND and load change_left = new credit - PRICE.
  - vend_req is asserted the cycle after entry, i.e. 1-cycle latency from the completing coin.
- VEND:
  - vend_req=1 until vend_ack is seen.
  - On vend_ack: vend_req drops next cycle; gruel=1; credit=0; go to HOLD.
  - cancel is ignored in VEND.
- HOLD:
  - gruel stays 1 for exactly HOLD_CYCLES cycles.
  - Then: if change_left=0 go to IDLE with gruel=0; otherwise go to CHANGE.
- Cancel in COLLECT:
  - Sets change_left = credit, credit=0, go to CHANGE.
  - Cancel in IDLE is a no-op.
- Simultaneous coin and cancel in COLLECT: the coin is added first, then the whole sum is refunded; no vend occurs even if the sum >= PRICE.
- change_total is loaded with change_left on entry to CHANGE and held until cleared by the next transaction.
- CHANGE:
  - change_req=1 while change_left>0.
  - Each change_ack decrements change_left by 1.
  - change_req deasserts for at least one cycle between units.
  - When change_left reaches 0: go to IDLE.
- Stray acks: vend_ack or change_ack received while the matching request is low is ignored.

Optional Feature:
- Macro: VEND_TIMEOUT_EN.
- Defined:
  - A counter runs in COLLECT and resets on every accepted coin.
  - Reaching TIMEOUT_CYCLES acts exactly like cancel: full refund through CHANGE.
  - Counter clears on reset and on leaving COLLECT.
- Undefined: no counter logic; COLLECT waits indefinitely.

Test Plan:
- Exact payment: PRICE=4, coins 1 then 3. Required: vend_req high 1 cycle after the second coin; vend_ack -> gruel high 8 cycles; then IDLE with change_total=0 and credit=0.
- Overpay: coins 3 then 3 (credit 6). Required: vend; after HOLD, CHANGE issues 2 change_req/change_ack pairs; change_total=2; final state IDLE.
- Cancel: coin 2 then cancel. Required: CHANGE refunds 2 units, no vend_req ever asserted; coin 1 with cancel in the same cycle after coin 2 refunds 3.
- Busy reject: coin_valid with value 2 during VEND. Required: coin_reject pulses 1 cycle and credit is unchanged.
- Reset during CHANGE with change_left=2: synchronous reset high for 1 cycle. Required: change_req=0, state=0, credit=0 next cycle.
- VEND_TIMEOUT_EN with TIMEOUT_CYCLES=16: coin 1 then idle. Required: after 16 cycles enters CHANGE and refunds 1 unit.

Source files
------------

// File: rtl/vend_sequencer.sv
// Purpose: gruel vending sequencer - coin credit, vend handshake, dispense hold, unit-wise change/refund.
// Latency: vend_req rises 1 cycle after the completing coin; change_req rises 1 cycle after CHANGE entry.
// Backpressure: vend_req/change_req held until acked; coins refused with coin_reject while busy. Optional macro: VEND_TIMEOUT_EN.
module vend_sequencer #(
    parameter int PRICE          = 4,
    parameter int HOLD_CYCLES    = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin_valid,
    input  logic [1:0] coin_value,
    input  logic       cancel,
    input  logic       vend_ack,
    input  logic       change_ack,
    output logic       vend_req,
    output logic       change_req,
    output logic       gruel,
    output logic       coin_reject,
    output logic [2:0] state,
    output logic [3:0] credit,
    output logic [2:0] change_total
);

    if (PRICE < 1 || PRICE > 12) begin : g_bad_price
        $error("vend_sequencer: PRICE must be 1..12");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("vend_sequencer: HOLD_CYCLES must be >= 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("vend_sequencer: TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_VEND    = 3'd2,
        S_HOLD    = 3'd3,
        S_CHANGE  = 3'd4
    } state_t;

    state_t      cur_state, nxt_state;
    logic [3:0]  credit_r, credit_d;
    logic [3:0]  change_left, change_left_d;
    logic [2:0]  change_total_r, change_total_d;
    logic        change_req_r, change_req_d;
    logic        coin_reject_r, coin_reject_d;
    logic [15:0] hold_cnt, hold_cnt_d;

    logic        coin_in;
    logic [3:0]  credit_sum;
    logic [3:0]  collect_credit;
    logic        timeout;
    logic        abort;

    assign coin_in    = coin_valid && (coin_value != 2'd0);
    assign credit_sum = credit_r + {2'b00, coin_value};
    // In COLLECT the coin is folded in before any cancel/threshold decision.
    assign collect_credit = coin_in ? credit_sum : credit_r;

`ifdef VEND_TIMEOUT_EN
    logic [15:0] to_cnt, to_cnt_d;

    assign timeout = (cur_state == S_COLLECT) && !coin_in && (to_cnt == 16'(TIMEOUT_CYCLES - 1));

    // Idle counter: runs only while staying in COLLECT without a new coin.
    always_comb begin
        to_cnt_d = 16'd0;
        if (cur_state == S_COLLECT && nxt_state == S_COLLECT && !coin_in)
            to_cnt_d = to_cnt + 16'd1;
    end

    // Idle counter register.
    always_ff @(posedge clk) begin
        if (reset) to_cnt <= 16'd0;
        else       to_cnt <= to_cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    assign abort = cancel || timeout;

    // Next-state and next-datapath decode.
    always_comb begin
        nxt_state      = cur_state;
        credit_d       = credit_r;
        change_left_d  = change_left;
        change_total_d = change_total_r;
        change_req_d   = change_req_r;
        coin_reject_d  = 1'b0;
        hold_cnt_d     = hold_cnt;
        case (cur_state)
            S_IDLE: begin
                // A single large coin can complete the price straight from IDLE.
                if (coin_in) begin
                    credit_d       = credit_sum;
                    change_total_d = 3'd0;
                    if (credit_sum >= 4'(PRICE)) begin
                        nxt_state     = S_VEND;
                        change_left_d = credit_sum - 4'(PRICE);
                    end else begin
                        nxt_state = S_COLLECT;
                    end
                end
            end
            S_COLLECT: begin
                if (abort) begin
                    change_left_d  = collect_credit;
                    change_total_d = collect_credit[2:0];
                    credit_d       = 4'd0;
                    change_req_d   = 1'b0;
                    nxt_state      = S_CHANGE;
                end else if (coin_in) begin
                    credit_d = credit_sum;
                    if (credit_sum >= 4'(PRICE)) begin
                        nxt_state     = S_VEND;
                        change_left_d = credit_sum - 4'(PRICE);
                    end
                end
            end
            S_VEND: begin
                coin_reject_d = coin_in;
                if (vend_ack) begin
                    credit_d   = 4'd0;
                    hold_cnt_d = 16'd0;
                    nxt_state  = S_HOLD;
                end
            end
            S_HOLD: begin
                coin_reject_d = coin_in;
                if (hold_cnt == 16'(HOLD_CYCLES - 1)) begin
                    hold_cnt_d = 16'd0;
                    if (change_left == 4'd0) begin
                        nxt_state = S_IDLE;
                    end else begin
                        change_total_d = change_left[2:0];
                        change_req_d   = 1'b0;
                        nxt_state      = S_CHANGE;
                    end
                end else begin
                    hold_cnt_d = hold_cnt + 16'd1;
                end
            end
            S_CHANGE: begin
                coin_reject_d = coin_in;
                if (change_left == 4'd0) begin
                    change_req_d = 1'b0;
                    nxt_state    = S_IDLE;
                end else if (change_req_r && change_ack) begin
                    // Drop the request for a cycle after each released unit.
                    change_left_d = change_left - 4'd1;
                    change_req_d  = 1'b0;
                    if (change_left == 4'd1) nxt_state = S_IDLE;
                end else begin
                    change_req_d = 1'b1;
                end
            end
            default: begin
                nxt_state     = S_IDLE;
                credit_d      = 4'd0;
                change_left_d = 4'd0;
                change_req_d  = 1'b0;
                hold_cnt_d    = 16'd0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state      <= S_IDLE;
            credit_r       <= 4'd0;
            change_left    <= 4'd0;
            change_total_r <= 3'd0;
            change_req_r   <= 1'b0;
            coin_reject_r  <= 1'b0;
            hold_cnt       <= 16'd0;
        end else begin
            cur_state      <= nxt_state;
            credit_r       <= credit_d;
            change_left    <= change_left_d;
            change_total_r <= change_total_d;
            change_req_r   <= change_req_d;
            coin_reject_r  <= coin_reject_d;
            hold_cnt       <= hold_cnt_d;
        end
    end

    assign vend_req     = (cur_state == S_VEND);
    assign gruel        = (cur_state == S_HOLD);
    assign change_req   = change_req_r;
    assign coin_reject  = coin_reject_r;
    assign state        = cur_state;
    assign credit       = credit_r;
    assign change_total = change_total_r;

endmodule

// File: tb/tb_vend_sequencer.sv
// Purpose: directed self-checking bench for vend_sequencer (PRICE=4, HOLD_CYCLES=8, TIMEOUT_CYCLES=16).
// Latency: inputs driven 1ns after a rising edge, outputs sampled 1ns after the next one.
// Backpressure: acks are driven by the bench; every wait is cycle-bounded.
module tb_vend_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       coin_valid;
    logic [1:0] coin_value;
    logic       cancel;
    logic       vend_ack;
    logic       change_ack;
    logic       vend_req;
    logic       change_req;
    logic       gruel;
    logic       coin_reject;
    logic [2:0] state;
    logic [3:0] credit;
    logic [2:0] change_total;

    int checks = 0;
    int fails  = 0;
    bit vend_seen;

    vend_sequencer #(.PRICE(4), .HOLD_CYCLES(8), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_value(coin_value),
        .cancel(cancel), .vend_ack(vend_ack), .change_ack(change_ack),
        .vend_req(vend_req), .change_req(change_req), .gruel(gruel),
        .coin_reject(coin_reject), .state(state), .credit(credit),
        .change_total(change_total)
    );

    always #5 clk = ~clk;

    // Sticky record of any vend request, used by the refund scenarios.
    always @(posedge clk) if (vend_req === 1'b1) vend_seen <= 1'b1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input logic [1:0] v);
        coin_valid = 1'b1;
        coin_value = v;
        tick();
        coin_valid = 1'b0;
        coin_value = 2'd0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (state === s) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Acks every change unit; reports units released and missing request gaps.
    task automatic serve_change(output int units, output int gap_bad);
        units = 0;
        gap_bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (state !== 3'd4) break;
            if (change_req === 1'b1) begin
                units++;
                change_ack = 1'b1;
                tick();
                change_ack = 1'b0;
                if (change_req !== 1'b0) gap_bad++;
            end else begin
                tick();
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++; if (state !== 3'd0)        begin fails++; $display("FAIL reset_state: got %0d want 0", state); end
        checks++; if (credit !== 4'd0)       begin fails++; $display("FAIL reset_credit: got %0d want 0", credit); end
        checks++; if (vend_req !== 1'b0)     begin fails++; $display("FAIL reset_vend_req: got %b want 0", vend_req); end
        checks++; if (change_req !== 1'b0)   begin fails++; $display("FAIL reset_change_req: got %b want 0", change_req); end
        checks++; if (gruel !== 1'b0)        begin fails++; $display("FAIL reset_gruel: got %b want 0", gruel); end
        checks++; if (coin_reject !== 1'b0)  begin fails++; $display("FAIL reset_coin_reject: got %b want 0", coin_reject); end
        checks++; if (change_total !== 3'd0) begin fails++; $display("FAIL reset_change_total: got %0d want 0", change_total); end
    endtask

    task automatic test_exact_payment();
        int cnt;
        coin(2'd1);
        checks++; if (credit !== 4'd1) begin fails++; $display("FAIL exact_credit1: got %0d want 1", credit); end
        checks++; if (state !== 3'd1)  begin fails++; $display("FAIL exact_collect: got %0d want 1", state); end
        coin(2'd3);
        checks++; if (vend_req !== 1'b1) begin fails++; $display("FAIL exact_vend_req_latency: got %b want 1", vend_req); end
        checks++; if (credit !== 4'd4)   begin fails++; $display("FAIL exact_credit4: got %0d want 4", credit); end
        tick();
        tick();
        checks++; if (vend_req !== 1'b1) begin fails++; $display("FAIL exact_vend_req_held: got %b want 1", vend_req); end
        vend_ack = 1'b1;
        tick();
        vend_ack = 1'b0;
        checks++; if (vend_req !== 1'b0) begin fails++; $display("FAIL exact_vend_req_drop: got %b want 0", vend_req); end
        checks++; if (credit !== 4'd0)   begin fails++; $display("FAIL exact_credit_clear: got %0d want 0", credit); end
        cnt = (gruel === 1'b1) ? 1 : 0;
        for (int i = 0; i < 20 && gruel === 1'b1; i++) begin
            tick();
            if (gruel === 1'b1) cnt++;
        end
        checks++; if (cnt != 8)              begin fails++; $display("FAIL exact_gruel_cycles: got %0d want 8", cnt); end
        checks++; if (state !== 3'd0)        begin fails++; $display("FAIL exact_end_idle: got %0d want 0", state); end
        checks++; if (change_total !== 3'd0) begin fails++; $display("FAIL exact_change_total: got %0d want 0", change_total); end
    endtask

    task automatic test_overpay();
        bit ok;
        int units, gap_bad;
        coin(2'd3);
        coin(2'd3);
        checks++; if (credit !== 4'd6) begin fails++; $display("FAIL over_credit: got %0d want 6", credit); end
        vend_ack = 1'b1;
        tick();
        vend_ack = 1'b0;
        wait_state(3'd4, 30, ok);
        checks++; if (!ok)                   begin fails++; $display("FAIL over_reach_change: state %0d want 4", state); end
        checks++; if (change_total !== 3'd2) begin fails++; $display("FAIL over_change_total: got %0d want 2", change_total); end
        serve_change(units, gap_bad);
        checks++; if (units != 2)            begin fails++; $display("FAIL over_units: got %0d want 2", units); end
        checks++; if (gap_bad != 0)          begin fails++; $display("FAIL over_req_gap: got %0d gaps missing want 0", gap_bad); end
        checks++; if (state !== 3'd0)        begin fails++; $display("FAIL over_end_idle: got %0d want 0", state); end
        checks++; if (change_total !== 3'd2) begin fails++; $display("FAIL over_total_held: got %0d want 2", change_total); end
    endtask

    task automatic test_cancel();
        int units, gap_bad;
        vend_seen = 1'b0;
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        checks++; if (state !== 3'd0) begin fails++; $display("FAIL cancel_idle_noop: got %0d want 0", state); end
        coin(2'd2);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        checks++; if (state !== 3'd4)        begin fails++; $display("FAIL cancel_to_change: got %0d want 4", state); end
        checks++; if (credit !== 4'd0)       begin fails++; $display("FAIL cancel_credit: got %0d want 0", credit); end
        checks++; if (change_total !== 3'd2) begin fails++; $display("FAIL cancel_total2: got %0d want 2", change_total); end
        serve_change(units, gap_bad);
        checks++; if (units != 2)            begin fails++; $display("FAIL cancel_units2: got %0d want 2", units); end
        // Coin and cancel together: coin counted, then whole sum refunded.
        coin(2'd2);
        cancel = 1'b1;
        coin(2'd1);
        cancel = 1'b0;
        checks++; if (change_total !== 3'd3) begin fails++; $display("FAIL cancel_total3: got %0d want 3", change_total); end
        serve_change(units, gap_bad);
        checks++; if (units != 3)            begin fails++; $display("FAIL cancel_units3: got %0d want 3", units); end
        // Sum reaching PRICE with cancel still refunds, no vend.
        coin(2'd3);
        cancel = 1'b1;
        coin(2'd3);
        cancel = 1'b0;
        checks++; if (change_total !== 3'd6) begin fails++; $display("FAIL cancel_total6: got %0d want 6", change_total); end
        serve_change(units, gap_bad);
        checks++; if (units != 6)            begin fails++; $display("FAIL cancel_units6: got %0d want 6", units); end
        checks++; if (gap_bad != 0)          begin fails++; $display("FAIL cancel_req_gap: got %0d gaps missing want 0", gap_bad); end
        checks++; if (vend_seen !== 1'b0)    begin fails++; $display("FAIL cancel_no_vend: got %b want 0", vend_seen); end
        checks++; if (state !== 3'd0)        begin fails++; $display("FAIL cancel_end_idle: got %0d want 0", state); end
    endtask

    task automatic test_busy_reject();
        bit ok;
        coin_valid = 1'b1;
        coin_value = 2'd0;
        tick();
        coin_valid = 1'b0;
        checks++; if (state !== 3'd0) begin fails++; $display("FAIL zero_coin_ignored: got state %0d want 0", state); end
        coin(2'd3);
        coin(2'd1);
        change_ack = 1'b1;
        cancel = 1'b1;
        coin(2'd2);
        change_ack = 1'b0;
        cancel = 1'b0;
        checks++; if (coin_reject !== 1'b1) begin fails++; $display("FAIL busy_reject_pulse: got %b want 1", coin_reject); end
        checks++; if (credit !== 4'd4)      begin fails++; $display("FAIL busy_credit_kept: got %0d want 4", credit); end
        checks++; if (state !== 3'd2)       begin fails++; $display("FAIL busy_cancel_ignored: got %0d want 2", state); end
        checks++; if (change_req !== 1'b0)  begin fails++; $display("FAIL busy_stray_ack: got %b want 0", change_req); end
        tick();
        checks++; if (coin_reject !== 1'b0) begin fails++; $display("FAIL busy_reject_one_cycle: got %b want 0", coin_reject); end
        vend_ack = 1'b1;
        tick();
        vend_ack = 1'b0;
        coin(2'd1);
        checks++; if (coin_reject !== 1'b1) begin fails++; $display("FAIL hold_reject_pulse: got %b want 1", coin_reject); end
        wait_state(3'd0, 30, ok);
        checks++; if (!ok || credit !== 4'd0) begin fails++; $display("FAIL busy_end_idle: state %0d credit %0d want 0 0", state, credit); end
    endtask

    task automatic test_reset_in_change();
        bit ok;
        coin(2'd3);
        coin(2'd3);
        vend_ack = 1'b1;
        tick();
        vend_ack = 1'b0;
        wait_state(3'd4, 30, ok);
        for (int i = 0; i < 5 && change_req !== 1'b1; i++) tick();
        checks++; if (!ok || change_req !== 1'b1) begin fails++; $display("FAIL rst_chg_setup: state %0d req %b want 4 1", state, change_req); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (change_req !== 1'b0)   begin fails++; $display("FAIL rst_chg_req: got %b want 0", change_req); end
        checks++; if (state !== 3'd0)        begin fails++; $display("FAIL rst_chg_state: got %0d want 0", state); end
        checks++; if (credit !== 4'd0)       begin fails++; $display("FAIL rst_chg_credit: got %0d want 0", credit); end
        checks++; if (change_total !== 3'd0) begin fails++; $display("FAIL rst_chg_total: got %0d want 0", change_total); end
        tick();
        checks++; if (state !== 3'd0 || change_req !== 1'b0) begin fails++; $display("FAIL rst_chg_stays_idle: state %0d req %b want 0 0", state, change_req); end
    endtask

    task automatic test_timeout();
        int n, units, gap_bad;
        coin(2'd1);
`ifdef VEND_TIMEOUT_EN
        n = 0;
        while (state === 3'd1 && n < 100) begin
            tick();
            n++;
        end
        checks++; if (n != 16 || state !== 3'd4) begin fails++; $display("FAIL timeout_cycles: got %0d cycles state %0d want 16 4", n, state); end
`else
        for (int i = 0; i < 40; i++) tick();
        checks++; if (state !== 3'd1) begin fails++; $display("FAIL no_timeout_wait: got %0d want 1", state); end
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
`endif
        serve_change(units, gap_bad);
        checks++; if (units != 1 || change_total !== 3'd1) begin fails++; $display("FAIL timeout_refund: units %0d total %0d want 1 1", units, change_total); end
        checks++; if (state !== 3'd0) begin fails++; $display("FAIL timeout_end_idle: got %0d want 0", state); end
    endtask

    initial begin
        reset = 1'b1;
        coin_valid = 1'b0;
        coin_value = 2'd0;
        cancel = 1'b0;
        vend_ack = 1'b0;
        change_ack = 1'b0;
        vend_seen = 1'b0;
        test_reset();
        test_exact_payment();
        test_overpay();
        test_cancel();
        test_busy_reject();
        test_reset_in_change();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

endmodule
